// File: rtl/memory_responder.sv
// Byte-serial RAM behind the CPU request/ready memory handshake; moves one byte per clock, little-endian.
// Define MEMORY_ALIGN_CHECK_EN to add memory_fault and reject misaligned halfword/word and size-3 requests.
module memory_responder #(
  parameter int ram_size    = 65536,
  parameter int wait_cycles = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  output logic [31:0] memory_data_in,
  input  logic [31:0] memory_data_out,
  input  logic [1:0]  memory_data_size,
  input  logic        memory_enable,
  input  logic        memory_operation,
  output logic        memory_ready
`ifdef MEMORY_ALIGN_CHECK_EN
  ,
  output logic        memory_fault
`endif
);
  localparam int AW = $clog2(ram_size);
  localparam int CW = (wait_cycles > 1) ? $clog2(wait_cycles) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, TRANSFER, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          op_q, op_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
`ifdef MEMORY_ALIGN_CHECK_EN
  logic          fault_q, fault_d;
`endif

  logic [7:0]    mem_q [ram_size];
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [7:0]    mem_wbyte;
  logic [1:0]    last_k;
  logic          skip_in, skip_q;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^memory_address[31:AW];

  // Requests that must complete without touching the array.
`ifdef MEMORY_ALIGN_CHECK_EN
  assign skip_in = (memory_data_size == 2'd3) ||
                   (memory_data_size == 2'd1 && memory_address[0]) ||
                   (memory_data_size == 2'd2 && memory_address[1:0] != 2'b00);
  assign skip_q  = (size_q == 2'd3) ||
                   (size_q == 2'd1 && addr_q[0]) ||
                   (size_q == 2'd2 && addr_q[1:0] != 2'b00);
`else
  assign skip_in = (memory_data_size == 2'd3);
  assign skip_q  = (size_q == 2'd3);
`endif

  assign last_k = (size_q == 2'd0) ? 2'd0 : (size_q == 2'd1) ? 2'd1 : 2'd3;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
`ifdef MEMORY_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    mem_we    = 1'b0;
    mem_idx   = addr_q + AW'(k_q);
    mem_wbyte = wdata_q[{k_q, 3'b000} +: 8];
    case (state_q)
      IDLE: begin
        if (memory_enable) begin
          addr_d  = memory_address[AW-1:0];
          size_d  = memory_data_size;
          op_d    = memory_operation;
          wdata_d = memory_data_out;
          k_d     = '0;
          cnt_d   = '0;
          if (!memory_operation) rdata_d = '0;
          if (wait_cycles > 0)   state_d = WAIT;
          else if (skip_in)      state_d = READY;
          else                   state_d = TRANSFER;
        end
      end
      WAIT: begin
        if (!memory_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(wait_cycles - 1)) begin
          cnt_d   = '0;
          state_d = skip_q ? READY : TRANSFER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRANSFER: begin
        if (!memory_enable) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          if (op_q) mem_we = 1'b1;
          else      rdata_d[{k_q, 3'b000} +: 8] = mem_q[mem_idx];
          if (k_q == last_k) begin
            k_d     = '0;
            state_d = READY;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      READY: begin
        // Ready is registered here so it rises one edge after the last byte.
        if (memory_enable) begin
          ready_d = 1'b1;
`ifdef MEMORY_ALIGN_CHECK_EN
          fault_d = skip_q;
`endif
        end else begin
          ready_d = 1'b0;
`ifdef MEMORY_ALIGN_CHECK_EN
          fault_d = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
`ifdef MEMORY_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
`ifdef MEMORY_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_idx] <= mem_wbyte;
  end

  assign memory_data_in = rdata_q;
  assign memory_ready   = ready_q;
`ifdef MEMORY_ALIGN_CHECK_EN
  assign memory_fault   = fault_q;
`endif

endmodule
